// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module : memory_stage
// Desc   : Pipeline MEM stage: request/grant/valid data-memory handshake with
//          stall, 8-bit timeout, sticky error and halt flags. Defining
//          MEMORY_STAGE_ALIGN_CHECK_EN rejects odd byte addresses.
// Rev    : 1.0 - initial release
// ============================================================================
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [15:0] addr,
  input  logic [15:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  output logic        memReq,
  output logic        memWe,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic        memGrant,
  input  logic        memValid,
  input  logic [15:0] memRdata,
  output logic [15:0] readDataOut,
  output logic        stall,
  output logic        memErr,
  output logic        haltOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Last counted value before the counter would reach 255.
  localparam logic [7:0] C_TO_LAST = 8'd254;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_to;
  logic        r_rd;
  logic        r_halt_pend;
  logic        r_memWe;
  logic [15:0] r_memAddr;
  logic [15:0] r_memWdata;
  logic [15:0] r_rdata;
  logic        r_memErr;
  logic        r_haltOut;

  logic w_access;
  logic w_misalign;
  logic w_timeout;

  assign w_access  = inValid & (memRead | memWrite) & ~r_haltOut;
  assign w_timeout = (r_to == C_TO_LAST);

`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
  assign w_misalign = addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A valid response beats the timeout; the timeout beats a late grant.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_next = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_next = S_DONE;
        end else if (memGrant) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memValid || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    memReq = 1'b0;
    case (r_state)
      S_IDLE: stall = w_access;
      S_REQ: begin
        stall  = 1'b1;
        memReq = 1'b1;
      end
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to        <= 8'd0;
      r_rd        <= 1'b0;
      r_halt_pend <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= 16'd0;
      r_memWdata  <= 16'd0;
      r_rdata     <= 16'd0;
      r_memErr    <= 1'b0;
      r_haltOut   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_memAddr   <= addr;
            r_memWdata  <= writeData;
            r_memWe     <= memWrite;
            r_rd        <= memRead & ~memWrite;
            r_halt_pend <= halt;
            r_to        <= 8'd0;
            if ((memRead && memWrite) || w_misalign) begin
              r_memErr <= 1'b1;
            end
            if (w_misalign && memRead && !memWrite) begin
              r_rdata <= 16'd0;
            end
          end else if (inValid && halt) begin
            r_haltOut <= 1'b1;
          end
        end
        S_REQ: begin
          r_to <= r_to + 8'd1;
          if (w_timeout) begin
            r_memErr <= 1'b1;
            if (r_rd) begin
              r_rdata <= 16'd0;
            end
          end
        end
        S_WAIT: begin
          r_to <= r_to + 8'd1;
          if (memValid) begin
            if (r_rd) begin
              r_rdata <= memRdata;
            end
          end else if (w_timeout) begin
            r_memErr <= 1'b1;
            if (r_rd) begin
              r_rdata <= 16'd0;
            end
          end
        end
        S_DONE: begin
          if (r_halt_pend) begin
            r_haltOut <= 1'b1;
          end
          r_halt_pend <= 1'b0;
        end
        default: r_halt_pend <= 1'b0;
      endcase
    end
  end

  assign memWe       = r_memWe;
  assign memAddr     = r_memAddr;
  assign memWdata    = r_memWdata;
  assign readDataOut = r_rdata;
  assign memErr      = r_memErr;
  assign haltOut     = r_haltOut;

endmodule
`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 inValid  in  1  EX/MEM register holds a fresh, not-yet-serviced instruction.
REQ-004 addr  in  16  ALU result, used as data-memory byte address.
REQ-005 writeData  in  16  store data (register read data 2).
REQ-006 memRead / memWrite / halt  in  1 each  control bits from EX/MEM.
REQ-007 memReq  out  1  memory request, held until memGrant.
REQ-008 memWe  out  1  request is a write; valid while memReq.
REQ-009 memAddr / memWdata  out  16 each  request address and data, registered, stable while memReq.
REQ-010 memGrant  in  1  memory accepted request this cycle.
REQ-011 memValid  in  1  read data valid or write acknowledged.
REQ-012 memRdata  in  16  read data, sampled only when memValid.
REQ-013 readDataOut  out  16  loaded data to MEM/WB; holds until next completed read.
REQ-014 stall  out  1  combinational; upstream pipeline holds while high.
REQ-015 memErr  out  1  sticky error flag.
REQ-016 haltOut  out  1  sticky halted flag.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE; one-hot or binary, encoding free.
REQ-018 Access = inValid & (memRead | memWrite) & ~haltOut; sampled only in IDLE.
REQ-019 IDLE + access: stall=1 same cycle; latch addr/writeData/memWrite into memAddr/memWdata/memWe; next state REQ.
REQ-020 REQ: memReq=1, stall=1; memGrant -> WAIT, else remain.
REQ-021 WAIT: memReq=0, stall=1; memValid -> DONE, capturing memRdata into readDataOut if read.
REQ-022 DONE: stall=0 for exactly one cycle (pipeline advances); next state IDLE; no new access sampled in DONE.
REQ-023 Minimum access latency: request seen cycle t, DONE at t+3 (grant at t+1, memValid at t+2).
REQ-024 memRead & memWrite both set: perform write, set memErr.
REQ-025 Timeout: 8-bit counter cleared on entering REQ, increments each cycle in REQ/WAIT; reaching 255 -> DONE, memErr=1, readDataOut=0 for a read, memReq dropped.
REQ-026 memValid outside WAIT and memGrant outside REQ are ignored.
REQ-027 IDLE + inValid & halt & no access: haltOut=1 next cycle, stall=0.
REQ-028 halt with access: access completes; haltOut set on the DONE cycle edge.
REQ-029 haltOut=1: no further access accepted; stall stays 0; cleared only by rst.
REQ-030 IDLE without access: stall=0, memReq=0, outputs hold.

Reset
REQ-031 rst=1 at edge from any state: state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, readDataOut=0, memErr=0, haltOut=0, timeout=0.
REQ-032 Reset mid-access abandons transaction; a later memValid is ignored.
REQ-033 stall=0 during the cycle following reset unless an access is presented.

Configuration
REQ-034 MEMORY_STAGE_ALIGN_CHECK_EN defined: access with addr[0]=1 issues no memReq; IDLE->DONE next cycle, memErr=1, readDataOut=0 for a read.
REQ-035 MEMORY_STAGE_ALIGN_CHECK_EN undefined: addr passed to memAddr unmodified; no alignment check, no error from it.

Verification
REQ-036 Read: addr=0x0010, memRead, grant at t+1, memValid+memRdata=0xBEEF at t+2 -> stall high t..t+2, low t+3, readDataOut=0xBEEF.
REQ-037 Write with grant delayed 3 cycles: addr=0x0020, writeData=0x1234 -> memReq held 3 cycles with memWe=1, memAddr/memWdata stable, no readDataOut change.
REQ-038 Timeout: read, memGrant at t+1, memValid never -> DONE after 255 counted cycles, memErr=1, readDataOut=0.
REQ-039 Halt with store -> store completes, haltOut=1 after DONE; subsequent memRead with inValid -> no memReq, stall=0.
REQ-040 rst in WAIT, memValid next cycle -> state IDLE, readDataOut=0, memErr=0.
REQ-041 With MEMORY_STAGE_ALIGN_CHECK_EN, read addr=0x0011 -> no memReq, stall one cycle, memErr=1; without macro -> normal access to 0x0011.
